// File: rtl/double_clk_gen_pkg.sv
// Shared types and helpers for the double_clk_gen block.
package double_clk_gen_pkg;

  localparam int unsigned CNT_W = 16;

  typedef logic [CNT_W-1:0] cnt_t;

  // The generator only ever idles or runs; leaving the run state is what
  // releases the lines.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // (cnt + div - phase) mod div, valid because cnt < div always holds.
  // One extra bit keeps the sum from overflowing near the top of the range.
  function automatic cnt_t lag_wrap(input cnt_t cnt, input cnt_t div, input cnt_t phase);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {1'b0, div} - {1'b0, phase};
    if (sum >= {1'b0, div}) begin
      lag_wrap = cnt_t'(sum - {1'b0, div});
    end else begin
      lag_wrap = sum[CNT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/double_clk_gen_tristate_buf.sv
// Pad driver for one generated clock line.
// Macro DOUBLE_CLK_GEN_OPEN_DRAIN_EN selects open-drain drive (only ever
// pulls low); otherwise the line is push-pull while enabled. Both modes look
// the same on a board with pull-ups.
module tristate_buf (
  input  logic data_i,
  input  logic oe_i,
  output wire  pad_o
);

`ifdef DOUBLE_CLK_GEN_OPEN_DRAIN_EN
  assign pad_o = (oe_i && !data_i) ? 1'b0 : 1'bz;
`else
  assign pad_o = oe_i ? data_i : 1'bz;
`endif

endmodule

// File: rtl/double_clk_gen.sv
// Two equal-frequency clocks divided from clk; clk1 lags clk0 by a quarter
// period. Both lines float (pulled high externally) while idle, and a stop
// request is only honoured at the end of a period so no runt pulse appears.
// Optional macro DOUBLE_CLK_GEN_OPEN_DRAIN_EN: open-drain pad drive.
module double_clk_gen
  import double_clk_gen_pkg::*;
#(
  parameter int unsigned CLK_DIV = 10
) (
  output wire  clk0,
  output wire  clk1,
  input  logic rst,
  input  logic en,
  input  logic clk
);

  localparam cnt_t DIV   = cnt_t'(CLK_DIV);
  localparam cnt_t HALF  = cnt_t'(CLK_DIV / 2);
  localparam cnt_t PHASE = cnt_t'(CLK_DIV / 4);
  localparam cnt_t LAST  = cnt_t'(CLK_DIV - 1);

  state_t state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  logic   c0_q, c0_d;
  logic   c1_q, c1_d;
  logic   oe_q, oe_d;

  // State register; reset releases both lines immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      c0_q    <= 1'b1;
      c1_q    <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      oe_q    <= oe_d;
    end
  end

  // Next-state: period counter, registered clock levels and output enable.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    c0_d    = c0_q;
    c1_d    = c1_q;
    oe_d    = oe_q;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        c0_d = (cnt_q >= HALF);
        c1_d = (lag_wrap(cnt_q, DIV, PHASE) >= HALF);
        oe_d = 1'b1;
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (!en) begin
            // Both levels are high here, so letting go is glitch-free.
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            c0_d    = 1'b1;
            c1_d    = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        c0_d    = 1'b1;
        c1_d    = 1'b1;
        oe_d    = 1'b0;
      end
    endcase
  end

  tristate_buf u_buf_clk0 (
    .data_i (c0_q),
    .oe_i   (oe_q),
    .pad_o  (clk0)
  );

  tristate_buf u_buf_clk1 (
    .data_i (c1_q),
    .oe_i   (oe_q),
    .pad_o  (clk1)
  );

endmodule

// File: tb/tb_double_clk_gen.sv
// Directed bench for double_clk_gen with CLK_DIV=10 and board pull-ups.
module tb_double_clk_gen;

  logic clk;
  logic rst;
  logic en;
  wire  clk0_w;
  wire  clk1_w;

  pullup (clk0_w);
  pullup (clk1_w);

  int errors;
  int checks;
  int ph;
  int falls;
  logic prev0;

  // Hand-derived levels indexed by the cnt value seen at the clocking edge:
  // clk0 high for cnt 5..9; clk1 low for cnt 2..6 (two cycles behind clk0).
  logic [9:0] pat0;
  logic [9:0] pat1;

  double_clk_gen #(.CLK_DIV(10)) dut (
    .clk0 (clk0_w),
    .clk1 (clk1_w),
    .rst  (rst),
    .en   (en),
    .clk  (clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_clk0"}, {15'd0, clk0_w}, 16'd1);
    check_val({tag, "_clk1"}, {15'd0, clk1_w}, 16'd1);
    check_val({tag, "_oe"},   {15'd0, dut.oe_q}, 16'd0);
    check_val({tag, "_cnt"},  dut.cnt_q, 16'd0);
  endtask

  // Runs n enabled cycles, checking both lines against the table and
  // counting clk0 falling edges.
  task automatic run_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      prev0 = clk0_w;
      tick();
      check_val({tag, "_clk0"}, {15'd0, clk0_w}, {15'd0, pat0[ph]});
      check_val({tag, "_clk1"}, {15'd0, clk1_w}, {15'd0, pat1[ph]});
      check_val({tag, "_oe"},   {15'd0, dut.oe_q}, 16'd1);
      ph = (ph + 1) % 10;
      check_val({tag, "_cnt"},  dut.cnt_q, 16'(ph));
      if (prev0 === 1'b1 && clk0_w === 1'b0) falls++;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    ph     = 0;
    falls  = 0;
    pat0   = 10'b11111_00000;
    pat1   = 10'b11100_00011;
    rst    = 1'b0;
    en     = 1'b0;
    #12;
    check_idle("reset");
    rst = 1'b1;
    tick();
    tick();
    check_idle("idle");

    // Start: first edge only arms the run flag, lines still released.
    en = 1'b1;
    tick();
    check_idle("arm");
    ph = 0;
    falls = 0;
    run_check("run100", 100);
    check_val("clk0_periods", 16'(falls), 16'd10);

    // Graceful stop: drop en at cnt=3, period finishes, released high.
    run_check("pre_stop", 3);
    check_val("stop_at_cnt3", dut.cnt_q, 16'd3);
    en = 1'b0;
    run_check("draining", 6);
    tick();
    check_idle("stopped");
    for (int i = 0; i < 5; i++) begin
      tick();
      check_idle("stay_idle");
    end

    // Drop at cnt=3, re-raise at cnt=6: no interruption through the wrap.
    en = 1'b1;
    tick();
    check_idle("rearm");
    ph = 0;
    run_check("glitch_a", 3);
    en = 1'b0;
    run_check("glitch_b", 3);
    en = 1'b1;
    run_check("glitch_c", 11);
    check_val("reset_at_cnt7", dut.cnt_q, 16'd7);
    check_val("clk1_low_before_rst", {15'd0, clk1_w}, 16'd0);

    // Asynchronous reset mid-period releases the lines before any edge.
    rst = 1'b0;
    #1;
    check_idle("async_rst");
    #2;
    rst = 1'b1;
    tick();
    check_idle("rearm_after_rst");
    ph = 0;
    run_check("restart", 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/double_clk_gen.md
Name: double_clk_gen

Overview:
- Generates two equal-frequency, phase-shifted clocks, clk0 and clk1, from the system clock.
- Frequency is the system clock divided by CLK_DIV; clk1 lags clk0 by a quarter period.
- Used as the clock source for two-wire/bit-banged serial peripherals.
- Outputs are tri-statable, so board pull-ups hold both lines high while the block is idle.

Parameters:
- CLK_DIV, 10, system-clock cycles per output period; even, 4..65534.
- PHASE (localparam), CLK_DIV/4 (floor), lag of clk1 behind clk0 in system cycles.
- HALF (localparam), CLK_DIV/2, cycles spent low and cycles spent high per period.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- clk0  output  1  generated clock, tri-state; high-Z when idle.
- clk1  output  1  generated clock lagging clk0 by PHASE cycles, tri-state; high-Z when idle.
- en  input  1  run request, level-sensitive.
- Port order is fixed: clk0, clk1, rst, en, clk.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Registers:
  - cnt[15:0], period counter.
  - run, active flag.
  - c0_q, c1_q, output data registers.
  - oe_q, output enable.
- Reset (rst=0, asynchronous): cnt=0, run=0, c0_q=1, c1_q=1, oe_q=0. clk0 and clk1 are high-Z.
- Idle → running: in a cycle with run=0 and en=1, set run=1 and keep cnt=0.
- While run=1:
  - cnt increments each cycle; cnt==CLK_DIV-1 wraps to 0.
  - Next-state values: c0_q = (cnt >= HALF); c1_q = (((cnt + CLK_DIV - PHASE) mod CLK_DIV) >= HALF); oe_q = 1.
  - Outputs are registered, so they reflect cnt with one cycle of latency and are glitch-free.
- Output drive:
  - oe_q=1: clk0 = c0_q, clk1 = c1_q.
  - oe_q=0: both outputs high-Z.
- Shape per period, from the first enabled edge: clk0 low for HALF cycles, then high for HALF cycles. clk1 is the same waveform delayed by PHASE cycles.
- Graceful stop:
  - If en=0 while running, the current period completes. At the cycle where cnt==CLK_DIV-1 and en=0: run←0, cnt←0, oe_q←0.
  - Both lines are released while high, so no runt pulse occurs.
  - If en returns to 1 before the wrap, there is no interruption.
- en=1 at the wrap cycle: continuous operation, no gap between periods.
- Reset mid-operation: immediate release of both lines, all state cleared.
- cnt is 16 bits. It never exceeds CLK_DIV-1.

Optional Feature:
- Macro DOUBLE_CLK_GEN_OPEN_DRAIN_EN.
- Defined: both outputs are open-drain. A line drives 0 when its data bit is 0 and oe_q=1; otherwise it is high-Z. High levels rely on external pull-ups.
- Undefined: push-pull while oe_q=1, as specified above.
- Waveforms seen through pull-ups are identical in both modes.

Decomposition:
- No shared package needed; CLK_DIV-derived localparams stay local.
- One natural sub-module: tristate_buf (data, oe → pad), instantiated twice. It holds the open-drain/push-pull macro selection.

Test Plan (CLK_DIV=10):
- Reset pulse with en=0 → clk0=clk1=1 via pull-ups (high-Z); cnt=0.
- Raise en → clk0 falls one cycle later, stays low 5 cycles, high 5, period exactly 10 cycles. clk1 falls 2 cycles after clk0 and rises 2 cycles after clk0 rises.
- en held high for 100 cycles → exactly 10 clk0 periods; clk1 lag constant at 2; no glitches at the cnt wrap.
- Drop en at cnt=3 → clocks continue until cnt=9, then both lines are released high; no pulse shorter than 5 cycles.
- Drop en at cnt=3 and re-raise at cnt=6 → output uninterrupted.
- Assert rst mid-period (cnt=7) → lines go high-Z asynchronously. Re-enable restarts from cnt=0.
